// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage driving the register-file write port.
// Formats load data, selects the result source and splits FP doubles into two beats.
`default_nettype none
`timescale 1ns/1ps

module writeback_stage #(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic             mem_mem2reg,
  input  logic             mem_jal,
  input  logic [1:0]       mem_fpoint,
  input  logic [1:0]       mem_dsize,
  input  logic             mem_loadext,
  input  logic [1:0]       mem_addr_lo,
  input  logic [31:0]      mem_alu,
  input  logic [31:0]      mem_alu_hi,
  input  logic [31:0]      mem_rdata,
  input  logic [31:0]      mem_rdata_hi,
  input  logic [31:0]      mem_link,
  output logic [4:0]       rw,
  output logic [31:0]      busW,
  output logic             wrenable,
  output logic [1:0]       fpoint,
  output logic             wb_stall,
  output logic [CNT_W-1:0] retire_count
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BEAT1 = 1'b1
  } state_t;

  state_t state, state_next;

  logic        st_valid;
  logic [4:0]  st_rd;
  logic        st_regwrite;
  logic        st_mem2reg;
  logic        st_jal;
  logic [1:0]  st_fpoint;
  logic [1:0]  st_dsize;
  logic        st_loadext;
  logic [1:0]  st_addr_lo;
  logic [31:0] st_alu;
  logic [31:0] st_alu_hi;
  logic [31:0] st_rdata;
  logic [31:0] st_rdata_hi;
  logic [31:0] st_link;

  logic [4:0]  dest;
  logic        write_ok;
  logic        is_double;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;
  logic [31:0] single_data;
  logic [31:0] hi_word;
  logic [31:0] lo_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      st_valid     <= 1'b0;
      st_rd        <= 5'd0;
      st_regwrite  <= 1'b0;
      st_mem2reg   <= 1'b0;
      st_jal       <= 1'b0;
      st_fpoint    <= 2'b00;
      st_dsize     <= 2'b00;
      st_loadext   <= 1'b0;
      st_addr_lo   <= 2'b00;
      st_alu       <= 32'd0;
      st_alu_hi    <= 32'd0;
      st_rdata     <= 32'd0;
      st_rdata_hi  <= 32'd0;
      st_link      <= 32'd0;
      retire_count <= '0;
    end else begin
      state <= state_next;
      if (!wb_stall) begin
        st_valid    <= mem_valid;
        st_rd       <= mem_rd;
        st_regwrite <= mem_regwrite;
        st_mem2reg  <= mem_mem2reg;
        st_jal      <= mem_jal;
        st_fpoint   <= mem_fpoint;
        st_dsize    <= mem_dsize;
        st_loadext  <= mem_loadext;
        st_addr_lo  <= mem_addr_lo;
        st_alu      <= mem_alu;
        st_alu_hi   <= mem_alu_hi;
        st_rdata    <= mem_rdata;
        st_rdata_hi <= mem_rdata_hi;
        st_link     <= mem_link;
      end
      if (st_valid && !wb_stall) begin
        retire_count <= retire_count + CNT_W'(1);
      end
    end
  end

  // Integer r0 is hardwired; FP f0 is a real register and stays writable.
  assign dest      = st_jal ? LINK_REG : st_rd;
  assign write_ok  = st_valid && (st_regwrite || st_jal) && (st_fpoint != 2'b11)
                     && !((st_fpoint == 2'b00) && (dest == 5'd0));
  assign is_double = write_ok && (st_fpoint == 2'b10);

  always_comb begin
    lane_byte = 8'd0;
    case (st_addr_lo)
      2'b00:   lane_byte = st_rdata[31:24];
      2'b01:   lane_byte = st_rdata[23:16];
      2'b10:   lane_byte = st_rdata[15:8];
      default: lane_byte = st_rdata[7:0];
    endcase
    lane_half = st_addr_lo[1] ? st_rdata[15:0] : st_rdata[31:16];
    load_fmt  = st_rdata;
    case (st_dsize)
      2'b00:   load_fmt = {{24{st_loadext & lane_byte[7]}}, lane_byte};
      2'b01:   load_fmt = {{16{st_loadext & lane_half[15]}}, lane_half};
      default: load_fmt = st_rdata;
    endcase
  end

  // Doubles take raw words; lane formatting applies only to single-register loads.
  assign single_data = st_jal ? st_link : (st_mem2reg ? load_fmt : st_alu);
  assign hi_word     = st_jal ? st_link : (st_mem2reg ? st_rdata_hi : st_alu_hi);
  assign lo_word     = st_jal ? st_link : (st_mem2reg ? st_rdata : st_alu);

  always_comb begin
    state_next = IDLE;
    wb_stall   = 1'b0;
    rw         = dest;
    busW       = single_data;
    wrenable   = write_ok;
    fpoint     = st_fpoint;
    case (state)
      IDLE: begin
        if (is_double) begin
          wb_stall   = 1'b1;
          busW       = hi_word;
          state_next = BEAT1;
        end
      end
      BEAT1: begin
        rw         = dest | 5'd1;
        busW       = lo_word;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed stimulus with a queue-based write-port scoreboard.
`default_nettype none
`timescale 1ns/1ps

module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid, mem_regwrite, mem_mem2reg, mem_jal, mem_loadext;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_fpoint, mem_dsize, mem_addr_lo;
  logic [31:0] mem_alu, mem_alu_hi, mem_rdata, mem_rdata_hi, mem_link;

  logic [4:0]  rw, rw4;
  logic [31:0] busW, busW4;
  logic        wrenable, wrenable4, wb_stall, wb_stall4;
  logic [1:0]  fpoint, fpoint4;
  logic [31:0] retire_count;
  logic [3:0]  retire_count4;

  writeback_stage #(.LINK_REG(5'd31), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_mem2reg(mem_mem2reg), .mem_jal(mem_jal),
    .mem_fpoint(mem_fpoint), .mem_dsize(mem_dsize), .mem_loadext(mem_loadext),
    .mem_addr_lo(mem_addr_lo), .mem_alu(mem_alu), .mem_alu_hi(mem_alu_hi),
    .mem_rdata(mem_rdata), .mem_rdata_hi(mem_rdata_hi), .mem_link(mem_link),
    .rw(rw), .busW(busW), .wrenable(wrenable), .fpoint(fpoint),
    .wb_stall(wb_stall), .retire_count(retire_count)
  );

  // Narrow counter instance exercises the modulo wrap in a few cycles.
  writeback_stage #(.LINK_REG(5'd31), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_rd(mem_rd),
    .mem_regwrite(mem_regwrite), .mem_mem2reg(mem_mem2reg), .mem_jal(mem_jal),
    .mem_fpoint(mem_fpoint), .mem_dsize(mem_dsize), .mem_loadext(mem_loadext),
    .mem_addr_lo(mem_addr_lo), .mem_alu(mem_alu), .mem_alu_hi(mem_alu_hi),
    .mem_rdata(mem_rdata), .mem_rdata_hi(mem_rdata_hi), .mem_link(mem_link),
    .rw(rw4), .busW(busW4), .wrenable(wrenable4), .fpoint(fpoint4),
    .wb_stall(wb_stall4), .retire_count(retire_count4)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rw;
    logic [31:0] data;
    logic [1:0]  fp;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] r, input logic [31:0] d, input logic [1:0] f);
    exp_q.push_back('{rw: r, data: d, fp: f});
  endtask

  always @(negedge clk) begin
    if (rst_n && wrenable) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write actual rw=%0d busW=0x%08h fp=%0d required no write",
                 rw, busW, fpoint);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rw, busW, fpoint} !== mon_e) begin
          failures++;
          $display("FAIL write_port actual rw=%0d busW=0x%08h fp=%0d required rw=%0d busW=0x%08h fp=%0d",
                   rw, busW, fpoint, mon_e.rw, mon_e.data, mon_e.fp);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the instruction was captured.
  task automatic drive(input logic v, input logic [4:0] rd, input logic rwr, input logic m2r,
                       input logic jal, input logic [1:0] fp, input logic [1:0] ds,
                       input logic ext, input logic [1:0] lo, input logic [31:0] alu,
                       input logic [31:0] alu_hi, input logic [31:0] rdata,
                       input logic [31:0] rdata_hi, input logic [31:0] link);
    int n;
    mem_valid = v;  mem_rd = rd;  mem_regwrite = rwr;  mem_mem2reg = m2r;  mem_jal = jal;
    mem_fpoint = fp;  mem_dsize = ds;  mem_loadext = ext;  mem_addr_lo = lo;
    mem_alu = alu;  mem_alu_hi = alu_hi;  mem_rdata = rdata;  mem_rdata_hi = rdata_hi;
    mem_link = link;
    n = 0;
    while (wb_stall && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      checks++;
      failures++;
      $display("FAIL stall_timeout actual=stalled required=released within 20 cycles");
    end
    @(negedge clk);
    mem_valid = 1'b0;
  endtask

  task automatic alu_wr(input logic [4:0] rd, input logic [1:0] fp, input logic [31:0] d);
    drive(1'b1, rd, 1'b1, 1'b0, 1'b0, fp, 2'b10, 1'b0, 2'b00, d, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0);
  endtask

  task automatic load_wr(input logic [4:0] rd, input logic [1:0] ds, input logic ext,
                         input logic [1:0] lo);
    drive(1'b1, rd, 1'b1, 1'b1, 1'b0, 2'b00, ds, ext, lo, 32'h5A5A_5A5A, 32'h0,
          32'h80FF_7F01, 32'h0, 32'h0);
  endtask

  logic [31:0] c0;

  initial begin
    mem_valid = 0;  mem_rd = 0;  mem_regwrite = 0;  mem_mem2reg = 0;  mem_jal = 0;
    mem_fpoint = 0;  mem_dsize = 0;  mem_loadext = 0;  mem_addr_lo = 0;
    mem_alu = 0;  mem_alu_hi = 0;  mem_rdata = 0;  mem_rdata_hi = 0;  mem_link = 0;

    repeat (2) @(negedge clk);
    check("rst_rw", 32'(rw), 32'd0);
    check("rst_busW", busW, 32'd0);
    check("rst_wrenable", 32'(wrenable), 32'd0);
    check("rst_fpoint", 32'(fpoint), 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    check("rst_count", retire_count, 32'd0);
    check("rst_narrow_port", {rw4, busW4[3:0], wrenable4, fpoint4, wb_stall4}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    expect_wr(5'd5, 32'h1234_5678, 2'b00);
    alu_wr(5'd5, 2'b00, 32'h1234_5678);

    expect_wr(5'd10, 32'hFFFF_FFFF, 2'b00);  load_wr(5'd10, 2'b00, 1'b1, 2'b01);
    expect_wr(5'd11, 32'h0000_0001, 2'b00);  load_wr(5'd11, 2'b00, 1'b0, 2'b11);
    expect_wr(5'd12, 32'hFFFF_80FF, 2'b00);  load_wr(5'd12, 2'b01, 1'b1, 2'b00);
    expect_wr(5'd13, 32'h80FF_7F01, 2'b00);  load_wr(5'd13, 2'b10, 1'b1, 2'b00);
    expect_wr(5'd14, 32'h0000_0080, 2'b00);  load_wr(5'd14, 2'b00, 1'b0, 2'b00);
    expect_wr(5'd15, 32'h0000_007F, 2'b00);  load_wr(5'd15, 2'b00, 1'b1, 2'b10);
    expect_wr(5'd16, 32'h0000_7F01, 2'b00);  load_wr(5'd16, 2'b01, 1'b0, 2'b10);
    expect_wr(5'd17, 32'h0000_7F01, 2'b00);  load_wr(5'd17, 2'b01, 1'b1, 2'b11);
    expect_wr(5'd18, 32'h80FF_7F01, 2'b00);  load_wr(5'd18, 2'b11, 1'b1, 2'b01);
    repeat (2) @(negedge clk);
    check("count_after_loads", retire_count, 32'd10);

    // FP double: second beat stalls the held ALU instruction behind it
    c0 = retire_count;
    expect_wr(5'd4, 32'hAAAA_0000, 2'b10);
    expect_wr(5'd5, 32'h0000_BBBB, 2'b10);
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00,
          32'h0000_BBBB, 32'hAAAA_0000, 32'h0, 32'h0, 32'h0);
    check("dbl_beat0_stall", 32'(wb_stall), 32'd1);
    check("dbl_beat0_count", retire_count, c0);
    expect_wr(5'd6, 32'h0000_0066, 2'b00);
    alu_wr(5'd6, 2'b00, 32'h0000_0066);
    check("dbl_count_once", retire_count, c0 + 32'd1);
    check("dbl_after_stall", 32'(wb_stall), 32'd0);

    expect_wr(5'd8, 32'h1111_2222, 2'b10);
    expect_wr(5'd9, 32'h3333_4444, 2'b10);
    drive(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'b01,
          32'h5555_5555, 32'h6666_6666, 32'h3333_4444, 32'h1111_2222, 32'h0);
    expect_wr(5'd3, 32'h0102_0304, 2'b10);
    expect_wr(5'd3, 32'h0506_0708, 2'b10);
    drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00,
          32'h0506_0708, 32'h0102_0304, 32'h0, 32'h0, 32'h0);
    drive(1'b1, 5'd20, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00,
          32'h1, 32'h2, 32'h0, 32'h0, 32'h0);
    check("dbl_suppressed_no_stall", 32'(wb_stall), 32'd0);

    expect_wr(5'd31, 32'h0040_0108, 2'b00);
    drive(1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00,
          32'h0, 32'h0, 32'h0, 32'h0, 32'h0040_0108);
    alu_wr(5'd0, 2'b00, 32'h0000_0BAD);
    expect_wr(5'd0, 32'h3F80_0000, 2'b01);
    alu_wr(5'd0, 2'b01, 32'h3F80_0000);
    alu_wr(5'd9, 2'b11, 32'h0000_0123);
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset during the second beat must abort that write
    expect_wr(5'd4, 32'hCAFE_0000, 2'b10);
    drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00,
          32'h0000_F00D, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rw", 32'(rw), 32'd0);
    check("midrst_busW", busW, 32'd0);
    check("midrst_wrenable", 32'(wrenable), 32'd0);
    check("midrst_fpoint", 32'(fpoint), 32'd0);
    check("midrst_stall", 32'(wb_stall), 32'd0);
    check("midrst_count", retire_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_beat1", 32'(exp_q.size()), 32'd0);

    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) expect_wr(5'(i + 1), 32'(i * 16 + 1), 2'b00);
      drive(1'b1, 5'(i + 1), (i % 2 == 0), 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00,
            32'(i * 16 + 1), 32'h0, 32'h0, 32'h0, 32'h0);
    end
    repeat (3) @(negedge clk);
    check("count_ten", retire_count, 32'd10);
    check("count4_ten", 32'(retire_count4), 32'd10);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00,
            32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    end
    repeat (2) @(negedge clk);
    check("count4_full", 32'(retire_count4), 32'd15);
    drive(1'b1, 5'd21, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00,
          32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    check("count4_wrap", 32'(retire_count4), 32'd0);
    check("count_sixteen", retire_count, 32'd16);

    repeat (3) @(negedge clk);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
